bus_ram_port: RTL and testbench

Parametrised bus-slave RAM port for the test-bench FPGA boards, and the next generation of the 8-bit bus RAM test block. It serves an external microprocessor-style bus with active-low read and write strobes. Write data comes from the 244 input buffer; read data is driven through a registered output with a separate output-enable for the top-level tri-state pad. Additions over the previous block:
- strobe synchronisation and edge-detected, single-shot access cycles
- a ready handshake
- auto-increment burst addressing
- sticky detection of read/write strobe conflicts

---
 rtl/bus_ram_pkg.sv | 24 ++
 rtl/bus_ram_port_if.sv | 36 +++
 rtl/bus_ram_port_strobe_sync.sv | 42 ++++
 rtl/bus_ram_port.sv | 146 ++++++++++++++
 tb/tb_bus_ram_port.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_ram_pkg
// Purpose : Shared definitions for the bus RAM port: default widths, the
//           synchroniser depth and the access FSM state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package bus_ram_pkg;

  localparam int DEF_AW          = 8;
  localparam int DEF_DW          = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_HOLD  = 3'd2,
    WR_HOLD  = 3'd3,
    CONFLICT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_ram_port_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_ram_port_if
// Purpose : Microprocessor-style bus between an external master and the
//           bus RAM port.
// Ports   : ABus/in244/bnRD/bnWR/bnINC  master -> slave
//           DOut/DOE/bRDY/err           slave  -> master
// Revision: 1.0  initial release
// ============================================================================
interface bus_ram_port_if
  import bus_ram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [AW-1:0] ABus;
  logic [DW-1:0] in244;
  logic          bnRD;
  logic          bnWR;
  logic          bnINC;
  logic [DW-1:0] DOut;
  logic          DOE;
  logic          bRDY;
  logic          err;

  modport master (
    output ABus, in244, bnRD, bnWR, bnINC,
    input  DOut, DOE, bRDY, err
  );

  modport slave (
    input  ABus, in244, bnRD, bnWR, bnINC,
    output DOut, DOE, bRDY, err
  );
endinterface
`default_nettype wire

// File: rtl/bus_ram_port_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module  : strobe_sync
// Purpose : Multi-stage synchroniser for an asynchronous active-low strobe,
//           with a registered single-cycle falling-edge pulse.
// Ports   : bclk     in   clock
//           bnRST    in   synchronous active-low reset
//           async_n  in   asynchronous strobe (active-low)
//           sync_n   out  synchronised level
//           fall     out  one-cycle pulse, high in the first cycle sync_n is low
// Revision: 1.0  initial release
// ============================================================================
module strobe_sync
  import bus_ram_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  wire logic bclk,
  input  wire logic bnRST,
  input  wire logic async_n,
  output logic      sync_n,
  output logic      fall
);

  logic [SYNC_STAGES-1:0] chain;

  // The pulse is computed from the same pair of stages that produces the next
  // synced level, so it lines up exactly with sync_n going low.
  always_ff @(posedge bclk) begin
    if (!bnRST) begin
      chain <= '1;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_n};
      fall  <= chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES-2];
    end
  end

  assign sync_n = chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bus_ram_port.sv
`default_nettype none
// ============================================================================
// Module  : bus_ram_port
// Purpose : Bus-slave RAM port with synchronised strobes, single-shot access
//           cycles, ready handshake, auto-increment bursts and sticky
//           read/write strobe conflict detection.
// Ports   : bclk   in   system clock
//           bnRST  in   synchronous active-low reset
//           bus    slave modport of bus_ram_port_if (address, write data,
//                  strobes, burst select, read data, DOE, bRDY, err)
// Revision: 1.0  initial release
// ============================================================================
module bus_ram_port
  import bus_ram_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int DEPTH       = 2**AW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  wire logic     bclk,
  input  wire logic     bnRST,
  bus_ram_port_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic rd_s, wr_s, inc_s;
  logic rd_fall, wr_fall, inc_fall_unused;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .bclk(bclk), .bnRST(bnRST), .async_n(bus.bnRD),  .sync_n(rd_s),  .fall(rd_fall));
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .bclk(bclk), .bnRST(bnRST), .async_n(bus.bnWR),  .sync_n(wr_s),  .fall(wr_fall));
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
    .bclk(bclk), .bnRST(bnRST), .async_n(bus.bnINC), .sync_n(inc_s), .fall(inc_fall_unused));

  state_t        state;
  logic [DW-1:0] dout;
  logic          doe, rdy, err;
  logic [AW-1:0] ptr;
  logic          burst;
  logic          rd_oor;
  logic [DW-1:0] q;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] eff_addr;
  logic [AW-1:0] next_ptr;
  logic          in_range, conflict, start_rd, start_wr;

  // A continuing burst uses the pointer; a fresh burst or a plain access uses ABus.
  always_comb begin
    eff_addr = bus.ABus;
    if (!inc_s && burst) eff_addr = ptr;
  end

  assign in_range = ({{(32-AW){1'b0}}, eff_addr} < DEPTH);
  assign next_ptr = ({{(32-AW){1'b0}}, ptr} >= DEPTH - 1) ? '0 : ptr + 1'b1;

  // Both strobes low anywhere is a conflict; so is a fresh edge of the other
  // strobe while an access is still open (it could otherwise be lost in the
  // release cycle where the first strobe is already high).
  assign conflict = (!rd_s && !wr_s)
                  || (wr_fall && (state == RD_WAIT || state == RD_HOLD))
                  || (rd_fall && state == WR_HOLD);

  assign start_rd = (state == IDLE) && rd_fall && !conflict;
  assign start_wr = (state == IDLE) && wr_fall && !conflict;

  // RAM is deliberately outside the reset so a write issued on a reset edge
  // still lands and contents survive reset.
  always_ff @(posedge bclk) begin
    if (start_wr && in_range) mem[eff_addr[IDX_W-1:0]] <= bus.in244;
    if (start_rd && in_range) q <= mem[eff_addr[IDX_W-1:0]];
  end

  always_ff @(posedge bclk) begin
    if (!bnRST) begin
      state  <= IDLE;
      dout   <= '0;
      doe    <= 1'b0;
      rdy    <= 1'b0;
      err    <= 1'b0;
      ptr    <= '0;
      burst  <= 1'b0;
      rd_oor <= 1'b0;
    end else if (conflict) begin
      state <= CONFLICT;
      doe   <= 1'b0;
      rdy   <= 1'b0;
      err   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_rd || start_wr) begin
            if (inc_s) begin
              burst <= 1'b0;
            end else if (!burst) begin
              burst <= 1'b1;
              ptr   <= bus.ABus;
            end
          end
          if (start_rd) begin
            rd_oor <= !in_range;
            state  <= RD_WAIT;
          end else if (start_wr) begin
            rdy   <= 1'b1;
            state <= WR_HOLD;
          end
        end
        RD_WAIT: begin
          dout  <= rd_oor ? '0 : q;
          doe   <= 1'b1;
          rdy   <= 1'b1;
          state <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rd_s) begin
            doe   <= 1'b0;
            rdy   <= 1'b0;
            state <= IDLE;
            if (burst) ptr <= next_ptr;
          end
        end
        WR_HOLD: begin
          if (wr_s) begin
            rdy   <= 1'b0;
            state <= IDLE;
            if (burst) ptr <= next_ptr;
          end
        end
        CONFLICT: begin
          if (rd_s && wr_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.DOut = dout;
  assign bus.DOE  = doe;
  assign bus.bRDY = rdy;
  assign bus.err  = err;

endmodule
`default_nettype wire

// File: tb/tb_bus_ram_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_ram_port
// Purpose : Self-checking bench for bus_ram_port. Two instances share the
//           bus stimulus: dut0 with full depth, dut1 with DEPTH=200 for the
//           out-of-range behaviour.
// Ports   : none
// Revision: 1.0  initial release
// ============================================================================
module tb_bus_ram_port;

  localparam int SYNC = 2;

  logic       bclk = 1'b0;
  logic       bn_rst;
  logic [7:0] abus, din;
  logic       rd_n, wr_n, inc_n;

  int checks = 0;
  int errors = 0;

  always #5 bclk = ~bclk;

  bus_ram_port_if #(.AW(8), .DW(8)) bus0 ();
  bus_ram_port_if #(.AW(8), .DW(8)) bus1 ();

  assign bus0.ABus  = abus;  assign bus1.ABus  = abus;
  assign bus0.in244 = din;   assign bus1.in244 = din;
  assign bus0.bnRD  = rd_n;  assign bus1.bnRD  = rd_n;
  assign bus0.bnWR  = wr_n;  assign bus1.bnWR  = wr_n;
  assign bus0.bnINC = inc_n; assign bus1.bnINC = inc_n;

  bus_ram_port #(.AW(8), .DW(8), .DEPTH(256), .SYNC_STAGES(SYNC)) dut0 (
    .bclk(bclk), .bnRST(bn_rst), .bus(bus0));
  bus_ram_port #(.AW(8), .DW(8), .DEPTH(200), .SYNC_STAGES(SYNC)) dut1 (
    .bclk(bclk), .bnRST(bn_rst), .bus(bus1));

  typedef struct {
    bit         is_wr;
    bit         inc;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vt [12];

  task automatic tick(input int k);
    repeat (k) @(posedge bclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic inc,
                          input bit chk1, input string nm);
    int n;
    abus = a; din = d; inc_n = inc; wr_n = 1'b0;
    n = 0;
    while (bus0.bRDY !== 1'b1 && n < 16) begin tick(1); n++; end
    check({nm, "_rdy"}, {31'd0, bus0.bRDY}, 32'd1);
    if (chk1) check({nm, "_rdy1"}, {31'd0, bus1.bRDY}, 32'd1);
    tick(3);
    wr_n = 1'b1;
    n = 0;
    while (bus0.bRDY !== 1'b0 && n < 16) begin tick(1); n++; end
    check({nm, "_rdy_clr"}, {31'd0, bus0.bRDY}, 32'd0);
    inc_n = 1'b1;
    tick(2);
  endtask

  task automatic do_read(input logic [7:0] a, input logic inc, input logic [7:0] exp0,
                         input logic [7:0] exp1, input bit chk1, input string nm);
    int n;
    abus = a; inc_n = inc; rd_n = 1'b0;
    n = 0;
    while (bus0.DOE !== 1'b1 && n < 16) begin tick(1); n++; end
    check({nm, "_doe"},  {31'd0, bus0.DOE},  32'd1);
    check({nm, "_rdy"},  {31'd0, bus0.bRDY}, 32'd1);
    check({nm, "_dout"}, {24'd0, bus0.DOut}, {24'd0, exp0});
    if (chk1) begin
      check({nm, "_dout1"}, {24'd0, bus1.DOut}, {24'd0, exp1});
      check({nm, "_rdy1"},  {31'd0, bus1.bRDY}, 32'd1);
      check({nm, "_err1"},  {31'd0, bus1.err},  32'd0);
    end
    tick(2);
    rd_n = 1'b1;
    n = 0;
    while (bus0.DOE !== 1'b0 && n < 16) begin tick(1); n++; end
    check({nm, "_doe_clr"}, {31'd0, bus0.DOE}, 32'd0);
    inc_n = 1'b1;
    tick(2);
  endtask

  initial begin
    bit saw;

    // Burst writes with garbage ABus after the first, wrap at 0xFF, then
    // plain reads, then a burst read that also wraps.
    vt[0]  = '{1'b1, 1'b0, 8'hFE, 8'h11};
    vt[1]  = '{1'b1, 1'b0, 8'h3C, 8'h22};
    vt[2]  = '{1'b1, 1'b0, 8'hC3, 8'h33};
    vt[3]  = '{1'b0, 1'b1, 8'hFE, 8'h11};
    vt[4]  = '{1'b0, 1'b1, 8'hFF, 8'h22};
    vt[5]  = '{1'b0, 1'b1, 8'h00, 8'h33};
    vt[6]  = '{1'b0, 1'b0, 8'hFE, 8'h11};
    vt[7]  = '{1'b0, 1'b0, 8'h77, 8'h22};
    vt[8]  = '{1'b0, 1'b0, 8'h55, 8'h33};
    vt[9]  = '{1'b1, 1'b1, 8'h20, 8'h5A};
    vt[10] = '{1'b0, 1'b1, 8'h20, 8'h5A};
    vt[11] = '{1'b0, 1'b1, 8'h10, 8'hA5};

    bn_rst = 1'b0; rd_n = 1'b1; wr_n = 1'b1; inc_n = 1'b1;
    abus = 8'h00; din = 8'h00;
    tick(3);
    check("rst_dout", {24'd0, bus0.DOut}, 32'd0);
    check("rst_doe",  {31'd0, bus0.DOE},  32'd0);
    check("rst_rdy",  {31'd0, bus0.bRDY}, 32'd0);
    check("rst_err",  {31'd0, bus0.err},  32'd0);
    bn_rst = 1'b1;
    tick(2);

    // Write 0xA5 to 0x10 with bnWR low for 8 cycles, checking bRDY timing.
    abus = 8'h10; din = 8'hA5; wr_n = 1'b0;
    tick(SYNC);
    check("wr_rdy_early", {31'd0, bus0.bRDY}, 32'd0);
    tick(1);
    check("wr_rdy_on", {31'd0, bus0.bRDY}, 32'd1);
    tick(8 - SYNC - 1);
    wr_n = 1'b1;
    tick(SYNC);
    check("wr_rdy_hold", {31'd0, bus0.bRDY}, 32'd1);
    tick(1);
    check("wr_rdy_off", {31'd0, bus0.bRDY}, 32'd0);
    tick(2);

    // Read latency and release timing.
    abus = 8'h10; rd_n = 1'b0;
    tick(SYNC + 1);
    check("lat_doe_early", {31'd0, bus0.DOE}, 32'd0);
    tick(1);
    check("lat_doe",  {31'd0, bus0.DOE},  32'd1);
    check("lat_rdy",  {31'd0, bus0.bRDY}, 32'd1);
    check("lat_dout", {24'd0, bus0.DOut}, 32'hA5);
    tick(3);
    rd_n = 1'b1;
    tick(SYNC);
    check("rel_doe_hold", {31'd0, bus0.DOE}, 32'd1);
    tick(1);
    check("rel_doe",  {31'd0, bus0.DOE},  32'd0);
    check("rel_rdy",  {31'd0, bus0.bRDY}, 32'd0);
    check("rel_dout", {24'd0, bus0.DOut}, 32'hA5);
    tick(2);

    for (int i = 0; i < 12; i++) begin
      if (vt[i].is_wr)
        do_write(vt[i].addr, vt[i].data, vt[i].inc, 1'b0, $sformatf("v%0d", i));
      else
        do_read(vt[i].addr, vt[i].inc, vt[i].data, 8'h00, 1'b0, $sformatf("v%0d", i));
    end

    // Coincident strobe falls.
    do_write(8'h05, 8'h3C, 1'b1, 1'b0, "pre5");
    abus = 8'h05; din = 8'h77; rd_n = 1'b0; wr_n = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus0.DOE === 1'b1) saw = 1'b1;
    end
    check("cfl_doe_never", {31'd0, saw}, 32'd0);
    check("cfl_err", {31'd0, bus0.err},  32'd1);
    check("cfl_rdy", {31'd0, bus0.bRDY}, 32'd0);
    rd_n = 1'b1; wr_n = 1'b1;
    tick(6);
    check("cfl_err_sticky", {31'd0, bus0.err}, 32'd1);
    do_read(8'h05, 1'b1, 8'h3C, 8'h00, 1'b0, "cfl_mem");
    check("cfl_err_still", {31'd0, bus0.err}, 32'd1);
    bn_rst = 1'b0;
    tick(1);
    check("cfl_err_rst", {31'd0, bus0.err}, 32'd0);
    bn_rst = 1'b1;
    tick(2);

    // Reset while in RD_HOLD.
    abus = 8'h10; rd_n = 1'b0;
    begin
      int n = 0;
      while (bus0.DOE !== 1'b1 && n < 16) begin tick(1); n++; end
    end
    check("rh_doe", {31'd0, bus0.DOE}, 32'd1);
    tick(1);
    bn_rst = 1'b0;
    tick(1);
    check("rh_doe_rst",  {31'd0, bus0.DOE},  32'd0);
    check("rh_rdy_rst",  {31'd0, bus0.bRDY}, 32'd0);
    check("rh_dout_rst", {24'd0, bus0.DOut}, 32'd0);
    rd_n = 1'b1; bn_rst = 1'b1;
    tick(3);
    do_read(8'h10, 1'b1, 8'hA5, 8'h00, 1'b0, "rh_again");

    // Sub-period glitch on bnWR between clock edges.
    do_write(8'h30, 8'h42, 1'b1, 1'b0, "pre30");
    abus = 8'h30; din = 8'hEE;
    #1 wr_n = 1'b0;
    #5 wr_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus0.bRDY === 1'b1) saw = 1'b1;
    end
    check("glitch_rdy", {31'd0, saw}, 32'd0);
    do_read(8'h30, 1'b1, 8'h42, 8'h00, 1'b0, "glitch_mem");

    // Out-of-range on the DEPTH=200 instance.
    do_write(8'hF0, 8'h99, 1'b1, 1'b1, "oor_w");
    do_read(8'hF0, 1'b1, 8'h99, 8'h00, 1'b1, "oor_r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
